pipe_hazard_ctrl: RTL

- Parametrised pipeline stall/flush controller; next generation of the single-shot hazard unit.
- Supports N-stage pipelines, configurable branch/jump/memory resolve stages and multi-bubble load-use interlock.
- Adds a halt-drain FSM that retires in-flight instructions before asserting halted.
- Sits between the datapath pipeline latches and the cache hit signals; drives per-latch write-enable and flush plus the PC enable.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 38 +++
 rtl/pipe_hazard_ctrl_sat_counter.sv | 31 +++
 rtl/pipe_hazard_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Stage indices here are only defaults; the top module parameters override them.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        BUBBLE = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } hz_state_t;

    localparam int DEF_NSTAGES    = 5;
    localparam int DEF_JMP_STAGE  = 1;
    localparam int DEF_BR_STAGE   = 2;
    localparam int DEF_MEM_STAGE  = 3;
    localparam int DEF_CNT_W      = 32;
    localparam int LU_BUBBLES_MAX = 4;

    // Bits [k-1:0] set: selects every latch younger than stage k.
    function automatic logic [31:0] mask_below(input int k);
        if (k >= 32) begin
            mask_below = 32'hFFFF_FFFF;
        end else if (k <= 0) begin
            mask_below = 32'd0;
        end else begin
            mask_below = (32'd1 << k) - 32'd1;
        end
    endfunction

    function automatic logic [31:0] one_hot(input int k);
        if ((k >= 32) || (k < 0)) begin
            one_hot = 32'd0;
        end else begin
            one_hot = 32'd1 << k;
        end
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear; holds at all-ones.
module sat_counter
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_r;

    // Count events, stopping at the maximum value instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (clr) begin
            count_r <= '0;
        end else if (inc && (count_r != {CNT_W{1'b1}})) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller with multi-bubble load-use interlock and halt drain.
// Optional perf counters are built only when PIPE_PERF_EN is defined.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int NSTAGES    = DEF_NSTAGES,
    parameter int JMP_STAGE  = DEF_JMP_STAGE,
    parameter int BR_STAGE   = DEF_BR_STAGE,
    parameter int MEM_STAGE  = DEF_MEM_STAGE,
    parameter int LU_BUBBLES = 1,
    parameter int CNT_W      = DEF_CNT_W
)(
    input  logic               CLK,
    input  logic               nRST,
    input  logic               ihit,
    input  logic               dhit,
    input  logic               dmem_req,
    input  logic               ld_use,
    input  logic               jmp_taken,
    input  logic               br_taken,
    input  logic               halt_id,
    output logic               pc_we,
    output logic [NSTAGES-2:0] latch_we,
    output logic [NSTAGES-2:0] latch_flush,
    output logic               halted,
    output logic [CNT_W-1:0]   stall_cycles,
    output logic [CNT_W-1:0]   flush_count
);

    localparam int NL = NSTAGES - 1;
    localparam int CW = $clog2(NSTAGES + LU_BUBBLES_MAX + 1);

    localparam logic [31:0] JMP_MASK_W = mask_below(JMP_STAGE);
    localparam logic [31:0] BR_MASK_W  = mask_below(BR_STAGE);
    localparam logic [31:0] MEM_MASK_W = mask_below(MEM_STAGE);
    localparam logic [31:0] JMP_HOT_W  = one_hot(JMP_STAGE);
    localparam logic [31:0] MEM_HOT_W  = one_hot(MEM_STAGE);

    localparam logic [NL-1:0] JMP_MASK = JMP_MASK_W[NL-1:0];
    localparam logic [NL-1:0] BR_MASK  = BR_MASK_W[NL-1:0];
    localparam logic [NL-1:0] MEM_MASK = MEM_MASK_W[NL-1:0];
    localparam logic [NL-1:0] JMP_HOT  = JMP_HOT_W[NL-1:0];
    localparam logic [NL-1:0] MEM_HOT  = MEM_HOT_W[NL-1:0];
    localparam logic [NL-1:0] IF_HOT   = {{(NL-1){1'b0}}, 1'b1};

    localparam logic [CW-1:0] LU_LOAD    = CW'(LU_BUBBLES - 1);
    localparam logic [CW-1:0] DRAIN_LOAD = CW'(NSTAGES - 1 - JMP_STAGE);

    hz_state_t     state_r;
    hz_state_t     nxt_state_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] nxt_cnt_s;
    logic          pc_we_s;
    logic [NL-1:0] we_s;
    logic [NL-1:0] flush_s;
    logic          mem_stall_s;

    assign mem_stall_s = dmem_req && !dhit;

    // Priority decode of hazards into latch controls and the next FSM state.
    always_comb begin
        pc_we_s     = 1'b1;
        we_s        = {NL{1'b1}};
        flush_s     = {NL{1'b0}};
        nxt_state_s = state_r;
        nxt_cnt_s   = cnt_r;
        if (state_r == HALTED) begin
            pc_we_s = 1'b0;
            we_s    = {NL{1'b0}};
        end else if (mem_stall_s) begin
            pc_we_s = 1'b0;
            we_s    = ~MEM_MASK;
            flush_s = MEM_HOT;
        end else if (br_taken) begin
            // Any pending bubble or drain belongs to a younger, now-squashed instruction.
            flush_s     = BR_MASK;
            nxt_state_s = RUN;
            nxt_cnt_s   = {CW{1'b0}};
        end else if (jmp_taken) begin
            flush_s = JMP_MASK;
        end else if ((state_r == RUN) && ld_use) begin
            pc_we_s = 1'b0;
            we_s    = ~JMP_MASK;
            flush_s = JMP_HOT;
            if (LU_BUBBLES > 1) begin
                nxt_state_s = BUBBLE;
                nxt_cnt_s   = LU_LOAD;
            end else begin
                nxt_state_s = RUN;
            end
        end else if (state_r == BUBBLE) begin
            pc_we_s = 1'b0;
            we_s    = ~JMP_MASK;
            flush_s = JMP_HOT;
            if (cnt_r <= CW'(1)) begin
                nxt_state_s = RUN;
                nxt_cnt_s   = {CW{1'b0}};
            end else begin
                nxt_cnt_s = cnt_r - CW'(1);
            end
        end else if ((state_r == RUN) && halt_id) begin
            pc_we_s     = 1'b0;
            flush_s     = IF_HOT;
            nxt_state_s = DRAIN;
            nxt_cnt_s   = DRAIN_LOAD;
        end else if (state_r == DRAIN) begin
            pc_we_s = 1'b0;
            flush_s = IF_HOT;
            if (cnt_r <= CW'(1)) begin
                nxt_state_s = HALTED;
                nxt_cnt_s   = {CW{1'b0}};
            end else begin
                nxt_cnt_s = cnt_r - CW'(1);
            end
        end else if (!ihit) begin
            pc_we_s = 1'b0;
            flush_s = IF_HOT;
        end else begin
            nxt_state_s = state_r;
        end
    end

    // FSM state and bubble/drain countdown.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r <= RUN;
            cnt_r   <= {CW{1'b0}};
        end else begin
            state_r <= nxt_state_s;
            cnt_r   <= nxt_cnt_s;
        end
    end

    assign pc_we       = pc_we_s;
    assign latch_we    = we_s;
    assign latch_flush = flush_s;
    assign halted      = (state_r == HALTED);

`ifdef PIPE_PERF_EN
    logic inc_stall_s;
    logic inc_flush_s;

    assign inc_stall_s = !pc_we_s && (state_r != HALTED);
    assign inc_flush_s = (state_r != HALTED) && !mem_stall_s && (br_taken || jmp_taken);

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (CLK),
        .rst_n (nRST),
        .clr   (1'b0),
        .inc   (inc_stall_s),
        .count (stall_cycles)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (CLK),
        .rst_n (nRST),
        .clr   (1'b0),
        .inc   (inc_flush_s),
        .count (flush_count)
    );
`else
    assign stall_cycles = {CNT_W{1'b0}};
    assign flush_count  = {CNT_W{1'b0}};
`endif

endmodule
